// File: rtl/seq_det_arbiter_pkg.sv
// Shared definitions for the serial pattern-detector front end:
// one-hot controller states and the default word geometry.
package seq_det_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_FLUSH = 4'b0100,
    ST_CHECK = 4'b1000
  } state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_FLUSH_CYC = 1;

endpackage

// File: rtl/seq_det_arbiter_rr.sv
// Combinational round-robin picker: first eligible request at or above
// the pointer, wrapping at N_REQ. Masked channels are never eligible.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] eligible;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_elig
      assign eligible[gi] = req_i[gi] & ~mask_i[gi];
    end
  endgenerate

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin : g_search
      int cand;
      logic [IDX_W-1:0] cand_idx;
      cand = int'(ptr_i) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && eligible[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Time-shares one serial pattern detector between N_REQ requesters: grants
// round-robin, clears the detector, shifts the word MSB-first, reports the flag.
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int IDX_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   match,
  output logic [IDX_W-1:0]       match_ch,
  output logic                   det_din,
  output logic                   det_rst,
  input  logic                   det_flag
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
  localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(FLUSH_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_CH    = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic [IDX_W-1:0]   match_ch_q, match_ch_d;
  logic               det_rst_q, det_rst_d;

  logic [N_REQ-1:0]   done_mask;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  // The channel finishing this cycle still has req high; keep it from being re-granted.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign done_mask[gi] = done_q && (match_ch_q == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i  (req),
    .mask_i (done_mask),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      match_ch_q  <= '0;
      det_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      match_q     <= match_d;
      match_ch_q  <= match_ch_d;
      det_rst_q   <= det_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == LAST_BIT) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_cnt_q == LAST_FLUSH) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    match_d     = match_q;
    match_ch_d  = match_ch_q;
    det_rst_d   = det_rst_q;
    det_din     = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          shreg_d     = data[int'(arb_idx)*WIDTH +: WIDTH];
          gnt_d       = arb_gnt;
          win_d       = arb_idx;
          busy_d      = 1'b1;
          det_rst_d   = 1'b0;
          bit_cnt_d   = '0;
          flush_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FL_W'(1);
      end
      ST_CHECK: begin
        match_d    = det_flag;
        match_ch_d = win_q;
        done_d     = 1'b1;
        gnt_d      = '0;
        busy_d     = 1'b0;
        det_rst_d  = 1'b1;
        ptr_d      = (win_q == LAST_CH) ? '0 : win_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = match_q;
  assign match_ch = match_ch_q;
  assign det_rst  = det_rst_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter with a behavioural 8'hAA detector
// (shift register followed by a registered compare flag).
module tb_seq_det_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy, done, match;
  logic [1:0]  match_ch;
  logic        det_din, det_rst, det_flag;

  logic [7:0]  det_sh;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  seq_det_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .FLUSH_CYC (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .match_ch (match_ch),
    .det_din  (det_din),
    .det_rst  (det_rst),
    .det_flag (det_flag)
  );

  // Detector model: flag is one register behind the shift register.
  always @(posedge clk) begin
    if (det_rst) begin
      det_sh   <= 8'h00;
      det_flag <= 1'b0;
    end else begin
      det_sh   <= {det_sh[6:0], det_din};
      det_flag <= (det_sh == 8'hAA);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Follows one word from its grant to its done pulse.
  task automatic serve(input int ch, input logic exp_match, input logic [7:0] exp_bits,
                       input logic drop, output int done_at);
    int         waited;
    logic [7:0] bits;
    waited = 0;
    while (gnt == 4'b0000 && waited < 40) begin
      tick;
      waited++;
    end
    check_val("grant", gnt, 4'b0001 << ch);
    check_val("busy_on", busy, 1'b1);
    check_val("det_rst_low", det_rst, 1'b0);
    bits = 8'h00;
    for (int k = 0; k < 8; k++) begin
      bits = {bits[6:0], det_din};
      tick;
    end
    check_val("det_din_bits", bits, exp_bits);
    check_val("flush_din", det_din, 1'b0);
    tick;
    check_val("no_early_done", done, 1'b0);
    tick;
    done_at = cyc;
    check_val("done", done, 1'b1);
    check_val("match", match, exp_match);
    check_val("match_ch", match_ch, ch);
    check_val("det_rst_done", det_rst, 1'b1);
    check_val("gnt_clear", gnt, 4'b0000);
    check_val("busy_off", busy, 1'b0);
    $display("word ch%0d bits=%02h match=%0d done at cycle %0d", ch, bits, match, done_at);
    if (drop) req[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         d0, d1;
    int         dd [4];
    logic [7:0] words [3];
    words[0] = 8'hAB;
    words[1] = 8'h55;
    words[2] = 8'h00;

    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;
    repeat (3) tick;
    check_val("rst_gnt", gnt, 4'b0000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_match", match, 1'b0);
    check_val("rst_match_ch", match_ch, 2'd0);
    check_val("rst_det_din", det_din, 1'b0);
    check_val("rst_det_rst", det_rst, 1'b1);
    rst = 1'b0;
    tick;

    // All four contend: strict order 0..3, done every 11 cycles.
    data = {8'h00, 8'hAA, 8'h00, 8'hAA};
    req  = 4'b1111;
    tick;
    for (int ch = 0; ch < 4; ch++) begin
      serve(ch, (ch % 2) == 0, (ch % 2) == 0 ? 8'hAA : 8'h00, 1'b1, dd[ch]);
      if (ch > 0) check_val("done_spacing", dd[ch] - dd[ch-1], 11);
    end
    tick;
    check_val("idle_after_all", gnt, 4'b0000);

    // Single request on ch1; pointer is back at 0.
    data[15:8] = 8'hAA;
    req[1] = 1'b1;
    check_val("gnt_before_edge", gnt, 4'b0000);
    tick;
    check_val("gnt_one_edge", gnt, 4'b0010);
    serve(1, 1'b1, 8'hAA, 1'b1, d0);

    // Non-matching words on ch0.
    for (int i = 0; i < 3; i++) begin
      tick;
      data[7:0] = words[i];
      req[0] = 1'b1;
      tick;
      serve(0, 1'b0, words[i], 1'b1, d0);
    end

    // ch2 holds req through its done: not re-granted in the following cycle.
    tick;
    data[23:16] = 8'hAA;
    req[2] = 1'b1;
    tick;
    serve(2, 1'b1, 8'hAA, 1'b0, d0);
    tick;
    check_val("no_regrant", gnt, 4'b0000);
    req[2] = 1'b0;
    tick;
    check_val("still_idle", gnt, 4'b0000);

    // ch2 again, ch3 joins during the done cycle and goes next.
    req[2] = 1'b1;
    tick;
    serve(2, 1'b1, 8'hAA, 1'b0, d0);
    req[3] = 1'b1;
    serve(3, 1'b0, 8'h00, 1'b1, d1);
    check_val("ch3_spacing", d1 - d0, 11);
    serve(2, 1'b1, 8'hAA, 1'b1, d0);

    // Reset during SHIFT bit 4 aborts the word.
    tick;
    data[7:0] = 8'hAA;
    req[0] = 1'b1;
    tick;
    check_val("abort_grant", gnt, 4'b0001);
    repeat (4) tick;
    check_val("abort_bit4", det_din, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_gnt", gnt, 4'b0000);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_det_rst", det_rst, 1'b1);
    check_val("abort_det_din", det_din, 1'b0);
    check_val("abort_done", done, 1'b0);
    tick;
    tick;
    check_val("abort_no_done", done, 1'b0);
    rst = 1'b0;
    serve(0, 1'b1, 8'hAA, 1'b1, d0);

    // Data changes after the grant; the latched word is used.
    tick;
    data[7:0] = 8'hAA;
    req[0] = 1'b1;
    tick;
    data[7:0] = 8'h00;
    serve(0, 1'b1, 8'hAA, 1'b1, d0);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
